// File: rtl/f2h_msg_tx_if.sv
// Signal bundle between the NPU fabric, the f2h message transmitter and the host PIO.
// master = transmitter side, slave = fabric/host side.
interface f2h_msg_tx_if;
   logic        evt_move_done;
   logic        evt_ldst_done;
   logic        evt_cu_idle;
   logic        data_valid;
   logic [23:0] data_word;
   logic        data_ready;
   logic        host_ack;
   logic [31:0] f2h_pio32;
   logic        f2h_write;
   logic        overflow;
   logic        busy;

   modport master (
      input  evt_move_done,
      input  evt_ldst_done,
      input  evt_cu_idle,
      input  data_valid,
      input  data_word,
      input  host_ack,
      output data_ready,
      output f2h_pio32,
      output f2h_write,
      output overflow,
      output busy
   );

   modport slave (
      output evt_move_done,
      output evt_ldst_done,
      output evt_cu_idle,
      output data_valid,
      output data_word,
      output host_ack,
      input  data_ready,
      input  f2h_pio32,
      input  f2h_write,
      input  overflow,
      input  busy
   );
endinterface

// File: rtl/f2h_msg_tx.sv
// Host-bound message transmitter: coalesces NPU completion events and EU result words
// into tagged 32-bit PIO writes, paced by host credits and a minimum inter-write gap.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | wait for credit and a pending source; latch word on issue
//   SEND  | f2h_write strobe, seq++, credit--
//   GAP   | forced idle for GAP_CYCLES cycles so the HPS PIO keeps up
module f2h_msg_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int CREDITS    = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   f2h_msg_tx_if.master bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CREDITS + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_LOAD_I);
   localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

   localparam logic [3:0] TYPE_MOVE = 4'd1;
   localparam logic [3:0] TYPE_LDST = 4'd2;
   localparam logic [3:0] TYPE_CU   = 4'd3;
   localparam logic [3:0] TYPE_DATA = 4'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [7:0]    r_cnt_mv;
   logic [7:0]    r_cnt_ls;
   logic [7:0]    r_cnt_cu;
   logic [3:0]    r_seq;
   logic [CW-1:0] r_credit;
   logic [GW-1:0] r_gap;
   logic [31:0]   r_pio;
   logic          r_overflow;

   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic          w_push;
   logic          w_pop;
   logic          w_any_evt;
   logic          w_issue;
   logic          w_sel_mv;
   logic          w_sel_ls;
   logic          w_sel_cu;
   logic          w_sel_dt;
   logic [31:0]   w_msg;
   logic          w_cred_inc;
   logic          w_cred_dec;
   logic          w_write;
   logic          w_busy;

   function automatic logic [7:0] f_evt_next(input logic [7:0] cnt,
                                             input logic       pulse,
                                             input logic       clr);
      logic [7:0] nxt;
      nxt = cnt;
      if (clr) begin
         nxt = pulse ? 8'd1 : 8'd0;
      end else if (pulse && (cnt != 8'hFF)) begin
         nxt = cnt + 8'd1;
      end
      return nxt;
   endfunction

   // data FIFO: pointers carry one extra wrap bit to tell full from empty
   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full  = ((r_wr_ptr - r_rd_ptr) == FIFO_FULL);
   assign w_push       = bus.data_valid && !w_fifo_full;
   assign w_pop        = w_issue && w_sel_dt;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= bus.data_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (bus.data_valid && w_fifo_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // fixed priority; lower classes may starve
   assign w_any_evt = (r_cnt_mv != 8'd0) || (r_cnt_ls != 8'd0) || (r_cnt_cu != 8'd0);
   assign w_sel_mv  = (r_cnt_mv != 8'd0);
   assign w_sel_ls  = !w_sel_mv && (r_cnt_ls != 8'd0);
   assign w_sel_cu  = !w_sel_mv && !w_sel_ls && (r_cnt_cu != 8'd0);
   assign w_sel_dt  = !w_any_evt && !w_fifo_empty;

   always_comb begin
      w_msg = 32'd0;
      if (w_sel_mv) begin
         w_msg = {TYPE_MOVE, r_seq, 16'd0, r_cnt_mv};
      end else if (w_sel_ls) begin
         w_msg = {TYPE_LDST, r_seq, 16'd0, r_cnt_ls};
      end else if (w_sel_cu) begin
         w_msg = {TYPE_CU, r_seq, 16'd0, r_cnt_cu};
      end else if (w_sel_dt) begin
         w_msg = {TYPE_DATA, r_seq, r_mem[r_rd_ptr[AW-1:0]]};
      end
   end

   assign w_issue = (r_state == S_IDLE) && (r_credit != '0) &&
                    (w_any_evt || !w_fifo_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_mv <= 8'd0;
         r_cnt_ls <= 8'd0;
         r_cnt_cu <= 8'd0;
      end else begin
         r_cnt_mv <= f_evt_next(r_cnt_mv, bus.evt_move_done, w_issue && w_sel_mv);
         r_cnt_ls <= f_evt_next(r_cnt_ls, bus.evt_ldst_done, w_issue && w_sel_ls);
         r_cnt_cu <= f_evt_next(r_cnt_cu, bus.evt_cu_idle,   w_issue && w_sel_cu);
      end
   end

   // an ack coinciding with a write always nets out, even at full credit
   assign w_cred_dec = (r_state == S_SEND);
   assign w_cred_inc = bus.host_ack && ((r_credit != CRED_MAX) || w_cred_dec);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit <= CRED_MAX;
      end else begin
         case ({w_cred_inc, w_cred_dec})
            2'b10:   r_credit <= r_credit + 1'b1;
            2'b01:   r_credit <= r_credit - 1'b1;
            default: r_credit <= r_credit;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pio <= 32'd0;
         r_seq <= 4'd0;
         r_gap <= '0;
      end else begin
         if (w_issue) begin
            r_pio <= w_msg;
         end
         if (r_state == S_SEND) begin
            r_seq <= r_seq + 4'd1;
            r_gap <= GAP_LOAD;
         end else if ((r_state == S_GAP) && (r_gap != '0)) begin
            r_gap <= r_gap - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            if (r_gap == '0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_write = 1'b0;
      w_busy  = w_any_evt || !w_fifo_empty;
      if (r_state == S_SEND) begin
         w_write = 1'b1;
      end
      if (r_state != S_IDLE) begin
         w_busy = 1'b1;
      end
   end

   assign bus.f2h_pio32  = r_pio;
   assign bus.f2h_write  = w_write;
   assign bus.overflow   = r_overflow;
   assign bus.busy       = w_busy;
   assign bus.data_ready = !w_fifo_full;

endmodule

// File: tb/tb_f2h_msg_tx.sv
// Scoreboard bench for f2h_msg_tx: expected words queued at stimulus time, matched
// against each observed f2h_write strobe.
module tb_f2h_msg_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   f2h_msg_tx_if bus ();

   f2h_msg_tx #(
      .FIFO_DEPTH (8),
      .CREDITS    (1),
      .GAP_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] obs_word [0:511];
   int          obs_cyc  [0:511];
   int          obs_n = 0;
   int          obs_rd = 0;
   logic [31:0] exp_q [$];

   always @(negedge clk) begin
      if (rst_n && bus.f2h_write && (obs_n < 512)) begin
         obs_word[obs_n] <= bus.f2h_pio32;
         obs_cyc[obs_n]  <= cyc;
         obs_n           <= obs_n + 1;
      end
   end

   // host model: auto-ack each write one cycle later, or ack on request
   bit auto_en = 1'b0;
   int man_cnt = 0;
   int auto_done = 0;
   int man_done = 0;

   initial begin
      bus.host_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!auto_en) auto_done = obs_n;
         if (auto_en && (auto_done != obs_n)) begin
            bus.host_ack = 1'b1;
            auto_done++;
         end else if (man_done != man_cnt) begin
            bus.host_ack = 1'b1;
            man_done++;
         end else begin
            bus.host_ack = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic wait_write(input string tag, input int budget, output int wcyc);
      int k;
      logic [31:0] e;
      k = 0;
      wcyc = -1;
      while ((obs_n <= obs_rd) && (k < budget)) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (obs_n <= obs_rd) begin
         chk({tag, "_timeout"}, obs_n, obs_rd + 1);
      end else if (exp_q.size() == 0) begin
         chk({tag, "_unexpected"}, exp_q.size(), 1);
         obs_rd++;
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs_word[obs_rd], e);
         wcyc = obs_cyc[obs_rd];
         obs_rd++;
      end
   endtask

   task automatic drive(input logic mv, input logic ls, input logic cu,
                        input logic dv, input logic [23:0] w, output int start);
      @(posedge clk);
      #1;
      bus.evt_move_done = mv;
      bus.evt_ldst_done = ls;
      bus.evt_cu_idle   = cu;
      bus.data_valid    = dv;
      bus.data_word     = w;
      start = cyc;
      @(posedge clk);
      #1;
      bus.evt_move_done = 1'b0;
      bus.evt_ldst_done = 1'b0;
      bus.evt_cu_idle   = 1'b0;
      bus.data_valid    = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1);
   end

   initial begin
      int s;
      int w;
      int a;
      bus.evt_move_done = 1'b0;
      bus.evt_ldst_done = 1'b0;
      bus.evt_cu_idle   = 1'b0;
      bus.data_valid    = 1'b0;
      bus.data_word     = 24'd0;

      // reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pio", bus.f2h_pio32, 32'd0);
      chk("rst_write", bus.f2h_write, 1'b0);
      chk("rst_overflow", bus.overflow, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ready", bus.data_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // single move_done: write in cycle 2, busy through the gap
      auto_en = 1'b1;
      exp_q.push_back(32'h1000_0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, s);
      chk("t1_busy_pending", bus.busy, 1'b1);
      wait_write("t1_word", 20, w);
      chk("t1_latency", w - s, 2);
      @(negedge clk);
      chk("t1_busy_gap1", bus.busy, 1'b1);
      @(negedge clk);
      chk("t1_busy_gap2", bus.busy, 1'b1);
      @(negedge clk);
      chk("t1_busy_idle", bus.busy, 1'b0);
      chk("t1_single_write", obs_n, obs_rd);

      // one credit: second word waits for host_ack
      apply_reset();
      auto_en = 1'b0;
      exp_q.push_back(32'h40AB_CDEF);
      exp_q.push_back(32'h4100_0123);
      @(posedge clk);
      #1;
      bus.data_valid = 1'b1;
      bus.data_word  = 24'hABCDEF;
      @(posedge clk);
      #1;
      bus.data_word  = 24'h000123;
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      wait_write("t2_first", 20, w);
      repeat (20) @(negedge clk);
      #1;
      chk("t2_no_credit_hold", obs_n, obs_rd);
      chk("t2_busy_held", bus.busy, 1'b1);
      a = cyc;
      man_cnt++;
      wait_write("t2_second", 20, w);
      chk("t2_ack_latency", w - a, 3);

      // priority order and write spacing
      apply_reset();
      auto_en = 1'b1;
      exp_q.push_back(32'h2000_0001);
      exp_q.push_back(32'h3100_0001);
      exp_q.push_back(32'h4200_0055);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 24'h000055, s);
      wait_write("t3_ldst", 20, w);
      chk("t3_ldst_cycle", w - s, 2);
      wait_write("t3_cu", 20, w);
      chk("t3_cu_cycle", w - s, 6);
      wait_write("t3_data", 20, w);
      chk("t3_data_cycle", w - s, 10);

      // saturating event count while out of credit
      apply_reset();
      auto_en = 1'b0;
      exp_q.push_back(32'h1000_0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, s);
      wait_write("t4_first", 20, w);
      @(posedge clk);
      #1;
      bus.evt_move_done = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      bus.evt_move_done = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("t4_no_credit_hold", obs_n, obs_rd);
      exp_q.push_back(32'h1100_00FF);
      man_cnt++;
      wait_write("t4_saturated", 20, w);
      repeat (6) @(negedge clk);
      #1;
      chk("t4_single_write", obs_n, obs_rd);
      chk("t4_busy_done", bus.busy, 1'b0);

      // FIFO full, overflow sticky, dropped word never sent
      apply_reset();
      auto_en = 1'b0;
      exp_q.push_back(32'h1000_0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, s);
      wait_write("t5_first", 20, w);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         bus.data_valid = 1'b1;
         bus.data_word  = 24'h000100 + 24'(i);
         exp_q.push_back({4'h4, 4'(i + 1), 24'h000100 + 24'(i)});
      end
      @(posedge clk);
      #1;
      chk("t5_ready_full", bus.data_ready, 1'b0);
      chk("t5_no_overflow_yet", bus.overflow, 1'b0);
      bus.data_word = 24'h000BAD;
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      chk("t5_overflow_set", bus.overflow, 1'b1);
      auto_en = 1'b1;
      man_cnt++;
      for (int i = 0; i < 8; i++) begin
         wait_write("t5_drain", 30, w);
      end
      repeat (8) @(negedge clk);
      #1;
      chk("t5_no_extra_word", obs_n, obs_rd);
      chk("t5_overflow_sticky", bus.overflow, 1'b1);
      chk("t5_ready_again", bus.data_ready, 1'b1);
      chk("t5_busy_done", bus.busy, 1'b0);

      // seq wrap, then reset during the gap
      apply_reset();
      auto_en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         exp_q.push_back({4'h1, 4'(i % 16), 24'h000001});
         drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, s);
         wait_write("t6_seq", 20, w);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_pio", bus.f2h_pio32, 32'd0);
      chk("t6_rst_write", bus.f2h_write, 1'b0);
      chk("t6_rst_busy", bus.busy, 1'b0);
      chk("t6_rst_ready", bus.data_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      auto_en = 1'b0;
      exp_q.push_back(32'h1000_0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, s);
      wait_write("t6_post_reset", 20, w);
      chk("t6_post_reset_latency", w - s, 2);

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
